// File: rtl/stopwatch_mode_controller.sv
// Stopwatch/timer control FSM: debounced start/clear buttons, 4-mode preset latch, load sequencing, count tick.
// Optional build macro DONE_BLINK_EN adds a 'blank' output that blinks the display while in DONE.
module stopwatch_mode_controller #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 100,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic        clear_btn,
  input  logic [1:0]  mode_sel,
  input  logic [7:0]  set_time,
  input  logic        cnt_zero,
  input  logic        cnt_max,
  output logic        load,
  output logic [15:0] load_val,
  output logic        cnt_en,
  output logic        cnt_up,
  output logic [1:0]  state,
`ifdef DONE_BLINK_EN
  output logic        blank,
`endif
  output logic        done
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Button conditioning: bit 0 = start, bit 1 = clear
  logic [1:0] btn_raw;
  logic [1:0] press_p;
  assign btn_raw = {clear_btn, start_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_debounce
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            accept;

      // The accepted level flips on the DEBOUNCE_CYC-th consecutive differing sample;
      // the press pulse is that flip's rising edge, seen by the FSM on the same edge.
      assign accept      = (sync2_reg != stable_reg) && (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1));
      assign press_p[gi] = accept & sync2_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (accept) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
      end
    end
  endgenerate

  logic start_p, clear_p;
  assign start_p = press_p[0];
  assign clear_p = press_p[1];

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] preset_value(input logic [1:0] m, input logic [7:0] st);
    case (m)
      2'd0:    return 16'h0000;
      2'd3:    return 16'h9999;
      default: return {clamp_digit(st[7:4]), clamp_digit(st[3:0]), 8'h00};
    endcase
  endfunction

  state_t            state_reg, state_next;
  logic [1:0]        mode_reg, mode_next, mode_eff;
  logic              init_reg;
  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic              load_reg, load_next;
  logic [15:0]       load_val_reg, load_val_next;
  logic              cnt_en_reg, cnt_en_next;
  logic              cnt_up_reg, cnt_up_next;
  logic              done_reg;
  logic              terminal, tick;

  assign terminal = cnt_up_reg ? cnt_max : cnt_zero;
  assign tick     = (state_reg == S_RUN) && (pre_reg == PRE_W'(TICK_CYC - 1));

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    mode_eff    = mode_reg;
    load_next   = 1'b0;
    cnt_en_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // The mode is live in IDLE; a fresh selection (or the first cycle out of reset) reloads.
        mode_next = mode_sel;
        mode_eff  = mode_sel;
        if (clear_p || !init_reg || (mode_sel != mode_reg))
          load_next = 1'b1;
        if (!clear_p && start_p)
          state_next = terminal ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (clear_p) begin
          load_next  = 1'b1;
          state_next = S_IDLE;
        end else if (start_p) begin
          state_next = S_PAUSE;
        end else if (terminal) begin
          state_next = S_DONE;
        end else if (tick) begin
          cnt_en_next = 1'b1;
        end
      end
      S_PAUSE: begin
        if (clear_p) begin
          load_next  = 1'b1;
          state_next = S_IDLE;
        end else if (start_p) begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (clear_p) begin
          load_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
    endcase

    load_val_next = load_next ? preset_value(mode_eff, set_time) : load_val_reg;
    cnt_up_next   = (mode_next < 2'd2);
    // Prescaler restarts from zero on every entry to RUN so each run/resume gets a full period.
    pre_next      = (state_reg == S_RUN && state_next == S_RUN && !tick) ? pre_reg + PRE_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      mode_reg     <= 2'd0;
      init_reg     <= 1'b0;
      pre_reg      <= '0;
      load_reg     <= 1'b0;
      load_val_reg <= 16'h0000;
      cnt_en_reg   <= 1'b0;
      cnt_up_reg   <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      init_reg     <= 1'b1;
      pre_reg      <= pre_next;
      load_reg     <= load_next;
      load_val_reg <= load_val_next;
      cnt_en_reg   <= cnt_en_next;
      cnt_up_reg   <= cnt_up_next;
      done_reg     <= (state_next == S_DONE);
    end
  end

  assign load     = load_reg;
  assign load_val = load_val_reg;
  assign cnt_en   = cnt_en_reg;
  assign cnt_up   = cnt_up_reg;
  assign state    = state_reg;
  assign done     = done_reg;

`ifdef DONE_BLINK_EN
  // Blink half-period is a quarter second expressed in count ticks.
  localparam int BLINK_TICKS = (TICK_HZ / 4 > 0) ? TICK_HZ / 4 : 1;
  localparam int BLINK_CYC   = TICK_CYC * BLINK_TICKS;
  localparam int BL_W        = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BL_W-1:0] blink_cnt_reg;
  logic            blank_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (state_next != S_DONE || state_reg != S_DONE) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (blink_cnt_reg == BL_W'(BLINK_CYC - 1)) begin
      blink_cnt_reg <= '0;
      blank_reg     <= ~blank_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
    end
  end

  assign blank = blank_reg;
`endif

endmodule
